// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared definitions for the PS/2 keyboard controller.
//                Register offsets (word index = address[3:2]), status bit
//                positions, frame receiver state type and scancode type.
//                IRQ_PS2 is the interrupt line number this block drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Word offsets decoded from bus_address[3:2]
    localparam logic [1:0] PS2_REG_STATUS = 2'd0;
    localparam logic [1:0] PS2_REG_DATA   = 2'd1;
    localparam logic [1:0] PS2_REG_CTRL   = 2'd2;

    // STATUS register bit positions
    localparam int PS2_ST_RX_VALID  = 0;
    localparam int PS2_ST_ERROR     = 1;
    localparam int PS2_ST_OVERFLOW  = 2;
    localparam int PS2_ST_TIMEOUT   = 3;
    localparam int PS2_ST_COUNT_LSB = 8;

    // Interrupt line number used by the system bus for this peripheral
    localparam int IRQ_PS2 = 4;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } Ps2State_t;

    typedef logic [7:0] Scancode_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_controller_if
//  Description : CPU data-bus bundle for memory-mapped peripherals.
//                master : CPU side, drives strobes/address/write data/mask
//                slave  : peripheral side, returns read data and stall
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_keyboard_controller_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_mask;
    logic [31:0] bus_data_rd;
    logic        bus_stall;

    modport master (
        output bus_read, bus_write, bus_address, bus_data_wr, bus_mask,
        input  bus_data_rd, bus_stall
    );

    modport slave (
        input  bus_read, bus_write, bus_address, bus_data_wr, bus_mask,
        output bus_data_rd, bus_stall
    );
endinterface
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : PS/2 device-to-host frame receiver. Synchronises ps2_clk and
//                ps2_data, detects falling clock edges, assembles the
//                11-bit frame (start, 8 data LSB-first, odd parity, stop) and
//                aborts stalled frames with a watchdog.
//                Optional glitch filter on the clock: PS2_GLITCH_FILTER_EN.
//  Ports       : clk, rst_n          - system clock, async active-low reset
//                i_ps2_clk/i_ps2_data - raw asynchronous PS/2 lines
//                o_byte/o_byte_valid - received scancode + one-cycle strobe
//                o_error             - one-cycle pulse, bad parity or stop
//                o_timeout           - one-cycle pulse, partial frame aborted
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FILTER_LEN     = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_ps2_clk,
    input  wire logic i_ps2_data,
    output Scancode_t o_byte,
    output logic      o_byte_valid,
    output logic      o_error,
    output logic      o_timeout
);

    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic r_clk_prev;
    logic w_clk_src;
    logic w_sample;

    Ps2State_t r_state, w_state_nxt;
    logic [2:0]          r_bitcnt;
    Scancode_t           r_shift;
    logic                r_parity;
    logic [c_WDOG_W-1:0] r_wdog;
    logic                w_timeout;

    // Two-flop synchronisers; reset to 1 to match an idle (pulled-up) line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);

    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_filt_clk;

    // Filtered clock follows the input only after FILTER_LEN consecutive
    // cycles at the new level; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt <= '0;
            r_filt_clk <= 1'b1;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_filt_clk <= r_clk_s2;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_clk_src = r_filt_clk;
`else
    assign w_clk_src = r_clk_s2;

    logic w_unused_filter;
    assign w_unused_filter = (FILTER_LEN != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_clk_prev <= 1'b1;
        else        r_clk_prev <= w_clk_src;
    end

    assign w_sample = r_clk_prev & ~w_clk_src;
    assign o_byte   = r_shift;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PS2_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and strobes. A sample clears the watchdog, so a timeout
    // can only fire in a cycle without a sample.
    always_comb begin
        w_state_nxt  = r_state;
        o_byte_valid = 1'b0;
        o_error      = 1'b0;
        o_timeout    = 1'b0;
        w_timeout    = (r_state != PS2_IDLE) && !w_sample &&
                       (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_state_nxt = PS2_IDLE;
            o_timeout   = 1'b1;
        end else if (w_sample) begin
            case (r_state)
                PS2_IDLE:   if (!r_dat_s2) w_state_nxt = PS2_DATA;
                PS2_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = PS2_PARITY;
                PS2_PARITY: w_state_nxt = PS2_STOP;
                PS2_STOP: begin
                    w_state_nxt = PS2_IDLE;
                    // Odd parity over data+parity, and stop bit must be 1
                    if (r_dat_s2 && (^{r_shift, r_parity})) o_byte_valid = 1'b1;
                    else                                    o_error      = 1'b1;
                end
                default:    w_state_nxt = PS2_IDLE;
            endcase
        end
    end

    // Frame datapath and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_wdog   <= '0;
        end else begin
            if (w_sample || w_timeout || (r_state == PS2_IDLE)) r_wdog <= '0;
            else                                              r_wdog <= r_wdog + 1'b1;

            if (w_sample) begin
                case (r_state)
                    PS2_IDLE:   r_bitcnt <= '0;
                    PS2_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    PS2_PARITY: r_parity <= r_dat_s2;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_controller
//  Description : Memory-mapped PS/2 keyboard controller. Buffers received
//                scancodes in a FIFO and exposes STATUS (0x0), DATA (0x4)
//                and CTRL (0x8) registers. Optional clock glitch filter in
//                the receiver is enabled by defining PS2_GLITCH_FILTER_EN.
//  Ports       : clk, rst_n     - system clock, async active-low reset
//                bus (slave)    - CPU data bus; reads are combinational,
//                                 DATA read pops on the clock edge
//                i_ps2_clk/data - raw PS/2 lines
//                o_interrupt    - registered irq_en & rx_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FILTER_LEN     = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    ps2_keyboard_controller_if.slave  bus,
    input  wire logic                 i_ps2_clk,
    input  wire logic                 i_ps2_data,
    output logic                      o_interrupt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    Scancode_t w_rx_byte;
    logic      w_rx_valid, w_rx_err, w_rx_tmo;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_frame_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (i_ps2_clk),
        .i_ps2_data   (i_ps2_data),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_error      (w_rx_err),
        .o_timeout    (w_rx_tmo)
    );

    Scancode_t            r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr, r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_err, r_ovf, r_tmo, r_irq_en;

    logic [1:0]  w_sel;
    logic        w_empty, w_full, w_pop, w_push, w_ovf_set, w_status_wr;
    logic [31:0] w_rd;

    assign w_sel       = bus.bus_address[3:2];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop       = bus.bus_read && (w_sel == PS2_REG_DATA) && !w_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands
    assign w_push      = w_rx_valid && (!w_full || w_pop);
    assign w_ovf_set   = w_rx_valid && w_full && !w_pop;
    assign w_status_wr = bus.bus_write && (w_sel == PS2_REG_STATUS);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
            r_irq_en    <= 1'b0;
            o_interrupt <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Set events take priority over write-1-to-clear
            r_err <= w_rx_err  | (r_err & ~(w_status_wr & bus.bus_data_wr[PS2_ST_ERROR]));
            r_ovf <= w_ovf_set | (r_ovf & ~(w_status_wr & bus.bus_data_wr[PS2_ST_OVERFLOW]));
            r_tmo <= w_rx_tmo  | (r_tmo & ~(w_status_wr & bus.bus_data_wr[PS2_ST_TIMEOUT]));

            if (bus.bus_write && (w_sel == PS2_REG_CTRL)) r_irq_en <= bus.bus_data_wr[0];

            o_interrupt <= r_irq_en & ~w_empty;
        end
    end

    always_comb begin
        w_rd = '0;
        if (bus.bus_read) begin
            case (w_sel)
                PS2_REG_STATUS: begin
                    w_rd[PS2_ST_RX_VALID] = ~w_empty;
                    w_rd[PS2_ST_ERROR]    = r_err;
                    w_rd[PS2_ST_OVERFLOW] = r_ovf;
                    w_rd[PS2_ST_TIMEOUT]  = r_tmo;
                    w_rd[PS2_ST_COUNT_LSB +: 8] = 8'(r_count);
                end
                PS2_REG_DATA: if (!w_empty) w_rd[7:0] = r_mem[r_rptr];
                PS2_REG_CTRL: w_rd[0] = r_irq_en;
                default:      w_rd = '0;
            endcase
        end
    end

    assign bus.bus_data_rd = w_rd;
    assign bus.bus_stall   = 1'b0;

    logic w_unused_bus;
    assign w_unused_bus = &{1'b0, bus.bus_mask, bus.bus_address[31:4],
                            bus.bus_address[1:0], bus.bus_data_wr[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard_controller
//  Description : Self-checking bench for ps2_keyboard_controller. Drives PS/2
//                frames on the raw lines and bus accesses, comparing against
//                a queue-based model of the FIFO, sticky flags and irq enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_controller;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic irq;

    ps2_keyboard_controller_if bus ();

    ps2_keyboard_controller #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_interrupt (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [7:0] q[$];
    logic m_err = 1'b0, m_ovf = 1'b0, m_tmo = 1'b0, m_irq_en = 1'b0;
    logic [31:0] d;

    function automatic logic [31:0] m_status();
        return {16'b0, 8'(q.size()), 4'b0, m_tmo, m_ovf, m_err, (q.size() != 0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            #50;
            ps2_clk = 1'b0;
            #100;
            ps2_clk = 1'b1;
            #50;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = (~^b) ^ !par_ok;
        send_bits({stop_ok, p, b, 1'b0}, 11);
        if (!par_ok || !stop_ok)   m_err = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                       m_ovf = 1'b1;
        #40;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.bus_read    = 1'b1;
        bus.bus_address = {28'b0, a, 2'b00};
        #1 v = bus.bus_data_rd;
        @(negedge clk);
        bus.bus_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.bus_write   = 1'b1;
        bus.bus_address = {28'b0, a, 2'b00};
        bus.bus_data_wr = v;
        @(negedge clk);
        bus.bus_write = 1'b0;
        if (a == 2'd0) begin
            if (v[1]) m_err = 1'b0;
            if (v[2]) m_ovf = 1'b0;
            if (v[3]) m_tmo = 1'b0;
        end else if (a == 2'd2) begin
            m_irq_en = v[0];
        end
    endtask

    task automatic rd_data_chk(input string tag);
        logic [31:0] v;
        logic [31:0] e;
        e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'h0;
        bus_rd(2'd1, v);
        chk(tag, v, e);
    endtask

    task automatic status_chk(input string tag);
        logic [31:0] v;
        bus_rd(2'd0, v);
        chk(tag, v, m_status());
    endtask

    initial begin
        bus.bus_read    = 1'b0;
        bus.bus_write   = 1'b0;
        bus.bus_address = '0;
        bus.bus_data_wr = '0;
        bus.bus_mask    = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset_rd_idle", bus.bus_data_rd, 32'h0);
        chk("reset_stall", {31'b0, bus.bus_stall}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd0, d);
        chk("reset_status", d, 32'h0);
        bus_rd(2'd2, d);
        chk("reset_ctrl", d, 32'h0);

        // Good frame, irq disabled
        send_frame(8'h1C, 1, 1);
        bus_rd(2'd0, d);
        chk("f1c_status", d, 32'h0000_0101);
        chk("f1c_irq_off", {31'b0, irq}, 32'h0);
        rd_data_chk("f1c_data");
        bus_rd(2'd0, d);
        chk("f1c_status_after", d, 32'h0);

        // Interrupt path
        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2, d);
        chk("ctrl_rd", d, 32'h1);
        send_frame(8'hF0, 1, 1);
        chk("irq_on", {31'b0, irq}, 32'h1);
        rd_data_chk("ff0_data");
        chk("irq_lag", {31'b0, irq}, 32'h1);
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        bus_wr(2'd2, 32'h0);

        // Parity error, then W1C
        send_frame(8'h1C, 0, 1);
        bus_rd(2'd0, d);
        chk("parity_err", d, 32'h2);
        bus_wr(2'd0, 32'h2);
        bus_rd(2'd0, d);
        chk("w1c_err", d, 32'h0);

        // Bad stop bit
        send_frame(8'h33, 1, 0);
        status_chk("stop_err");
        bus_wr(2'd0, 32'h2);

        // Overflow
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1);
        bus_rd(2'd0, d);
        chk("ovf_status", d, 32'h0000_0405);
        for (int i = 1; i <= 4; i++) begin
            bus_rd(2'd1, d);
            chk("ovf_data", d, 32'(i));
            void'(q.pop_front());
        end
        bus_rd(2'd1, d);
        chk("empty_data", d, 32'h0);
        bus_rd(2'd0, d);
        chk("empty_status", d, 32'h4);
        bus_wr(2'd0, 32'h4);

        // Partial frame timeout, then a good frame
        send_bits(11'b0_0000_1111_0, 5);
        repeat (TMO + 50) @(negedge clk);
        m_tmo = 1'b1;
        bus_rd(2'd0, d);
        chk("timeout_bit", {31'b0, d[3]}, 32'h1);
        send_frame(8'h5A, 1, 1);
        status_chk("after_tmo_status");
        rd_data_chk("after_tmo_data");
        bus_wr(2'd0, 32'hE);
        status_chk("tmo_cleared");

        // Randomised traffic
        bus_wr(2'd2, 32'h1);
        for (int it = 0; it < 30; it++) begin
            int kind;
            logic [7:0] b;
            kind = $urandom_range(0, 5);
            b = 8'($urandom);
            send_frame(b, kind != 0, kind != 1);
            if ($urandom_range(0, 2) != 0) rd_data_chk("rnd_data");
            if ($urandom_range(0, 3) == 0) bus_wr(2'd0, {28'b0, 4'($urandom)});
            status_chk("rnd_status");
            chk("rnd_irq", {31'b0, irq}, {31'b0, m_irq_en && (q.size() != 0)});
        end
        while (q.size() != 0) rd_data_chk("drain_data");
        bus_wr(2'd0, 32'hE);

        // Reset mid-frame
        send_bits(11'b1_0000_0101_0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_err = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_irq_en = 1'b0;
        @(negedge clk);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        send_frame(8'h29, 1, 1);
        bus_rd(2'd0, d);
        chk("midrst_status", d, 32'h0000_0101);
        rd_data_chk("midrst_data");
        status_chk("midrst_empty");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
